motor_atributos: RTL
====================

// Module: motor_atributos
// PURPOSE
//  Parametrised pet-attribute engine for the Zanagotchi core, supporting N channels (hunger, happiness, sleep, ...).
//  - Each channel decays periodically on an internal prescaled tick.
//  - Channels are boosted by a ready/valid action request from the state controller.
//  - Raises sticky 'morreu' after a channel has sat at zero for a programmable number of ticks.
// PARAMETERS
//  N_ATTR      3         number of attribute channels (1..16)
//  WIDTH       8         bits per attribute
//  TICK_DIV    50000000  clk cycles per decay tick (>=2)
//  DECAY_STEP  1         amount subtracted per tick per channel
//  BOOST_STEP  16        amount added per accepted action
//  INIT_VAL    128       reset value of every channel (< 2**WIDTH)
//  CRIT_LVL    32        critico[i]=1 when attr[i] < CRIT_LVL
//  DEATH_TICKS 8         consecutive ticks with any channel at 0 before death (>=1)
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               synchronous reset, active low
//  acao_valid  in   1               action request
//  acao_idx    in   IW=$clog2(N_ATTR) (min 1)   channel to boost
//  acao_ready  out  1               engine can accept action this cycle
//  attr_flat   out  N_ATTR*WIDTH    channel i at [i*WIDTH +: WIDTH]
//  critico     out  N_ATTR          per-channel below-threshold flags, combinational from attr
//  tick        out  1               one-cycle pulse at prescaler wrap
//  morreu      out  1               sticky death flag
// BEHAVIOUR
//  - Reset (rst_n=0 at edge)
//    - All attr=INIT_VAL; prescaler=0, zero-tick counter=0, tick=0, morreu=0, acao_ready=0.
//    - FSM enters IDLE.
//    - Reset mid-decay or mid-boost aborts the operation with no partial update kept.
//  - Prescaler
//    - Counts 0..TICK_DIV-1 in every state except DEAD.
//    - tick=1 on the cycle the count equals TICK_DIV-1.
//  - FSM states:
//    - IDLE: acao_ready=1.
//      - tick=1 -> DECAY with k=0. Tick has priority: an action presented in the same cycle is not accepted (acao_ready=0 that cycle).
//      - else valid&&ready -> BOOST, latching acao_idx.
//    - DECAY: attr[k] <= (attr[k] < DECAY_STEP) ? 0 : attr[k]-DECAY_STEP.
//      - k increments each cycle. After k=N_ATTR-1 -> CHECK.
//      - Decay pass occupies N_ATTR cycles; acao_ready=0.
//    - CHECK: evaluates post-decay values.
//      - If any attr==0: zero-tick counter++, else counter=0.
//      - If counter reaches DEATH_TICKS -> DEAD. Else -> IDLE. acao_ready=0.
//    - BOOST: attr[idx] <= saturating add of BOOST_STEP, clamped at 2**WIDTH-1. Then -> IDLE.
//      - Value visible on attr_flat 2 cycles after the accepting edge.
//      - idx >= N_ATTR: no channel changes; the action is still consumed.
//    - DEAD: morreu=1, acao_ready=0.
//      - Attributes and prescaler frozen; tick held 0.
//      - Exit only by reset.
//  - A tick arriving while in BOOST is not lost: a pending flag is set.
//    - DECAY starts from IDLE next cycle with the flag cleared.
//    - TICK_DIV >= N_ATTR+2 is required so passes never overlap.
//  - Arithmetic is unsigned WIDTH-bit with explicit saturation; no wrap-around at 0 or at max.
//  - Zero-tick counter saturates at DEATH_TICKS; its width is $clog2(DEATH_TICKS+1).
// CONFIGURATION
//  ATTR_CROSS_PENALTY_EN defined:
//    - BOOST also decrements attr[(idx+1) % N_ATTR] by DECAY_STEP, floored at 0, in the same cycle.
//    - Skipped when N_ATTR==1 or idx is invalid.
//  ATTR_CROSS_PENALTY_EN undefined: BOOST touches only attr[idx]; no extra logic is generated.
// TESTING (N_ATTR=3, WIDTH=8, TICK_DIV=8, DECAY_STEP=1, BOOST_STEP=16, INIT_VAL=128, CRIT_LVL=32,
//          DEATH_TICKS=2)
//  1 Reset, idle 8 cycles -> tick pulses once.
//    Attrs go 128->127 on 3 successive cycles, channel 0 first; morreu=0.
//  2 attr0=250, action idx=0 in IDLE -> ready&&valid accepted, attr0=255 two cycles later (saturation).
//    With ATTR_CROSS_PENALTY_EN defined, attr1 also drops by 1.
//  3 Action asserted on the tick cycle -> not accepted that cycle.
//    Held valid, it is accepted at the first IDLE after CHECK; boost applied to the post-decay value.
//  4 Force attr2=1, run 3 ticks:
//    - tick1: attr2 0, counter 1.
//    - tick2: counter 2 -> DEAD, morreu=1, ready=0.
//    - Further ticks absent, attrs frozen.
//  5 Decrement a channel down to 31 -> critico[i] rises the cycle the value changes.
//    Boost to 47 -> critico[i] falls.
//  6 rst_n=0 during DECAY at k=1, and again in DEAD -> next cycle all attrs=128, morreu=0.
//    acao_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/motor_atributos.sv
// Pet-attribute engine: N channels decaying on a prescaled tick, boosted by actions, with sticky death flag.
// Optional ATTR_CROSS_PENALTY_EN: a boost also decays the next channel (idx+1 mod N_ATTR).
module motor_atributos #(
    parameter int N_ATTR      = 3,
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int DECAY_STEP  = 1,
    parameter int BOOST_STEP  = 16,
    parameter int INIT_VAL    = 128,
    parameter int CRIT_LVL    = 32,
    parameter int DEATH_TICKS = 8,
    localparam int IW         = (N_ATTR > 1) ? $clog2(N_ATTR) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acao_valid,
    input  logic [IW-1:0]           acao_idx,
    output logic                    acao_ready,
    output logic [N_ATTR*WIDTH-1:0] attr_flat,
    output logic [N_ATTR-1:0]       critico,
    output logic                    tick,
    output logic                    morreu
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ZW = $clog2(DEATH_TICKS + 1);

    localparam logic [WIDTH-1:0] INIT_W     = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] DEC_W      = WIDTH'(DECAY_STEP);
    localparam logic [WIDTH-1:0] BST_W      = WIDTH'(BOOST_STEP);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ZW-1:0]    DEATH_W    = ZW'(DEATH_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECAY,
        S_CHECK,
        S_BOOST,
        S_DEAD
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_attr [N_ATTR];
    logic [IW-1:0]    r_k;
    logic [IW-1:0]    r_idx;
    logic [ZW-1:0]    r_zero_cnt;
    logic             r_pend;
    logic             r_run;
    logic             r_morreu;

    logic             w_tick;
    logic             w_ready;
    logic             w_any_zero;
    logic [ZW-1:0]    w_zero_inc;

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v);
        return (v < DEC_W) ? '0 : v - DEC_W;
    endfunction

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {1'b0, v} + {1'b0, BST_W};
        return s[WIDTH] ? '1 : s[WIDTH-1:0];
    endfunction

    assign w_tick     = (r_presc == PRESC_LAST) && (r_state != S_DEAD);
    // r_run keeps ready low for the first cycle out of reset; tick and a pending pass outrank actions
    assign w_ready    = r_run && (r_state == S_IDLE) && !w_tick && !r_pend;
    assign w_zero_inc = (r_zero_cnt == DEATH_W) ? DEATH_W : r_zero_cnt + ZW'(1);

    always_comb begin
        w_any_zero = 1'b0;
        attr_flat  = '0;
        critico    = '0;
        for (int i = 0; i < N_ATTR; i++) begin
            if (r_attr[i] == '0) w_any_zero = 1'b1;
            attr_flat[i*WIDTH +: WIDTH] = r_attr[i];
            critico[i] = int'(r_attr[i]) < CRIT_LVL;
        end
    end

    assign acao_ready = w_ready;
    assign tick       = w_tick;
    assign morreu     = r_morreu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_state != S_DEAD) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_idx      <= '0;
            r_zero_cnt <= '0;
            r_pend     <= 1'b0;
            r_run      <= 1'b0;
            r_morreu   <= 1'b0;
            for (int i = 0; i < N_ATTR; i++) r_attr[i] <= INIT_W;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_tick || r_pend) begin
                        r_state <= S_DECAY;
                        r_k     <= '0;
                        r_pend  <= 1'b0;
                    end else if (acao_valid && w_ready) begin
                        r_state <= S_BOOST;
                        r_idx   <= acao_idx;
                    end
                end
                S_DECAY: begin
                    for (int i = 0; i < N_ATTR; i++) begin
                        if (r_k == IW'(i)) r_attr[i] <= sat_sub(r_attr[i]);
                    end
                    if (r_k == IW'(N_ATTR - 1)) r_state <= S_CHECK;
                    else                        r_k     <= r_k + IW'(1);
                    if (w_tick) r_pend <= 1'b1;
                end
                S_CHECK: begin
                    if (w_any_zero) begin
                        r_zero_cnt <= w_zero_inc;
                        if (w_zero_inc == DEATH_W) begin
                            r_state  <= S_DEAD;
                            r_morreu <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_zero_cnt <= '0;
                        r_state    <= S_IDLE;
                    end
                    if (w_tick) r_pend <= 1'b1;
                end
                S_BOOST: begin
                    // an out-of-range idx matches no channel, so the action is simply consumed
                    for (int i = 0; i < N_ATTR; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_attr[i] <= sat_add(r_attr[i]);
                        end
`ifdef ATTR_CROSS_PENALTY_EN
                        else if (N_ATTR > 1 && r_idx == IW'((i + N_ATTR - 1) % N_ATTR)) begin
                            r_attr[i] <= sat_sub(r_attr[i]);
                        end
`endif
                    end
                    r_state <= S_IDLE;
                    if (w_tick) r_pend <= 1'b1;
                end
                S_DEAD: begin
                    r_state <= S_DEAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
